// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests on the instruction bus and
// presents the oldest returned {pc, inst} to IF/ID from a small in-order prefetch buffer.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  stall_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        stallreq_o
);

   localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam int unsigned      SUM_W   = CNT_W + 1;
   localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
   localparam logic [31:0]      NOP     = 32'h0000_0013;
   localparam logic [31:0]      PC_INIT = {RESET_PC[31:2], 2'b00};

   logic [31:0]      pc_q, pc_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [CNT_W-1:0] count_q, count_d;   // allocated entries, filled plus pending
   logic [CNT_W-1:0] pend_q, pend_d;     // allocated entries still awaiting data
   logic [CNT_W-1:0] disc_q, disc_d;     // stale responses still to be dropped

   logic [31:0] buf_pc   [DEPTH];
   logic [31:0] buf_inst [DEPTH];

   logic             head_filled;
   logic             pop;
   logic             grant;
   logic             rsp_drop;
   logic             rsp_fill;
   logic [CNT_W-1:0] filled_cnt;
   logic [CNT_W-1:0] owed;
   logic [SUM_W-1:0] credit_used;
   logic [PTR_W-1:0] tail_idx;
   logic [PTR_W-1:0] fill_idx;
   logic             unused_bits;

   // Buffer status, credit check and bus handshake decode
   always_comb begin
      filled_cnt  = count_q - pend_q;
      head_filled = (filled_cnt != '0);
      pop         = ~jump_flag_i & ~stall_i[1] & head_filled;
      credit_used = SUM_W'(count_q) - SUM_W'(pop) + SUM_W'(disc_q);
      ibus_req_o  = rst_n & ~jump_flag_i & (credit_used < DEPTH_S);
      grant       = ibus_req_o & ibus_gnt_i;
      rsp_drop    = ibus_rvalid_i & (disc_q != '0);
      rsp_fill    = ibus_rvalid_i & (disc_q == '0) & (pend_q != '0) & ~jump_flag_i;
      tail_idx    = head_q + PTR_W'(count_q);
      fill_idx    = head_q + PTR_W'(filled_cnt);
      owed        = disc_q + pend_q;
   end

   // Next-state: a redirect empties the buffer and turns pending entries into discards
   always_comb begin
      pc_d    = pc_q;
      head_d  = head_q;
      count_d = count_q;
      pend_d  = pend_q;
      disc_d  = disc_q;
      if (jump_flag_i) begin
         pc_d    = {jump_addr_i[31:2], 2'b00};
         count_d = '0;
         pend_d  = '0;
         disc_d  = owed - CNT_W'(ibus_rvalid_i & (owed != '0));
      end else begin
         if (grant) begin
            pc_d = pc_q + 32'd4;
         end
         head_d  = head_q + PTR_W'(pop);
         count_d = count_q + CNT_W'(grant) - CNT_W'(pop);
         pend_d  = pend_q + CNT_W'(grant) - CNT_W'(rsp_fill);
         disc_d  = disc_q - CNT_W'(rsp_drop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= PC_INIT;
         head_q  <= '0;
         count_q <= '0;
         pend_q  <= '0;
         disc_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         count_q <= count_d;
         pend_q  <= pend_d;
         disc_q  <= disc_d;
      end
   end

   // Entry storage: PC written at grant, instruction written at fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            buf_pc[i]   <= '0;
            buf_inst[i] <= NOP;
         end
      end else begin
         if (grant) begin
            buf_pc[tail_idx] <= pc_q;
         end
         if (rsp_fill) begin
            buf_inst[fill_idx] <= ibus_rdata_i;
         end
      end
   end

   assign ibus_addr_o = pc_q;
   assign pc_o        = head_filled ? buf_pc[head_q]   : 32'h0000_0000;
   assign inst_o      = head_filled ? buf_inst[head_q] : NOP;
   assign stallreq_o  = ~head_filled;

   assign unused_bits = ^{stall_i[5:2], stall_i[0], jump_addr_i[1:0]};

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic, all checked every cycle
// against a queue-based model of the fetch buffer driven by an in-order bus responder.
module tb_if_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  stall;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        stallreq;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall),
      .jump_flag_i  (jump_flag),
      .jump_addr_i  (jump_addr),
      .ibus_req_o   (ibus_req),
      .ibus_addr_o  (ibus_addr),
      .ibus_gnt_i   (gnt),
      .ibus_rvalid_i(rvalid),
      .ibus_rdata_i (rdata),
      .pc_o         (pc),
      .inst_o       (inst),
      .stallreq_o   (stallreq)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int unsigned gnt_pct = 100;
   int unsigned rv_pct  = 100;

   // Reference model: next fetch PC, ready {pc,inst} queue, pending PCs, discard debt
   logic [31:0] m_pc;
   logic [31:0] m_rpc[$];
   logic [31:0] m_rinst[$];
   logic [31:0] m_pend[$];
   int          m_disc;

   // Bus responder: granted addresses in order, with earliest-return cycle
   logic [31:0] b_addr[$];
   int          b_due[$];

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h00C0_FFEE;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = RST_PC;
      m_disc = 0;
      m_rpc.delete();
      m_rinst.delete();
      m_pend.delete();
      b_addr.delete();
      b_due.delete();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req"},      32'(ibus_req),  32'h0);
      chk({tag, "_addr"},     ibus_addr,      RST_PC);
      chk({tag, "_pc"},       pc,             32'h0);
      chk({tag, "_inst"},     inst,           NOP);
      chk({tag, "_stallreq"}, 32'(stallreq),  32'h1);
   endtask

   task automatic drive_bus();
      gnt    = ($urandom_range(99) < gnt_pct);
      rvalid = 1'b0;
      rdata  = $urandom;
      if (b_addr.size() > 0 && b_due[0] <= cyc && $urandom_range(99) < rv_pct) begin
         rvalid = 1'b1;
         rdata  = mem(b_addr[0]);
      end
   endtask

   // One clock: drive bus, check at negedge, advance model and bus, resume after posedge
   task automatic step();
      bit          pop;
      bit          e_req;
      int          occ;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      drive_bus();
      @(negedge clk);
      pop    = !jump_flag && !stall[1] && m_rpc.size() > 0;
      occ    = m_rpc.size() + m_pend.size();
      e_req  = rst_n && !jump_flag && (occ - int'(pop) + m_disc < DEPTH);
      e_pc   = (m_rpc.size() > 0) ? m_rpc[0] : 32'h0;
      e_inst = (m_rinst.size() > 0) ? m_rinst[0] : NOP;
      chk("ibus_req",  32'(ibus_req), 32'(e_req));
      chk("ibus_addr", ibus_addr,     m_pc);
      chk("pc_o",      pc,            e_pc);
      chk("inst_o",    inst,          e_inst);
      chk("stallreq",  32'(stallreq), 32'(m_rpc.size() == 0));
      if (rvalid) begin
         void'(b_addr.pop_front());
         void'(b_due.pop_front());
      end
      if (ibus_req && gnt) begin
         b_addr.push_back(ibus_addr);
         b_due.push_back(cyc + 1);
      end
      if (rst_n) begin
         if (jump_flag) begin
            if (rvalid && (m_disc + m_pend.size()) > 0) m_disc = m_disc + m_pend.size() - 1;
            else m_disc = m_disc + m_pend.size();
            m_rpc.delete();
            m_rinst.delete();
            m_pend.delete();
            m_pc = {jump_addr[31:2], 2'b00};
         end else begin
            if (pop) begin
               void'(m_rpc.pop_front());
               void'(m_rinst.pop_front());
            end
            if (rvalid) begin
               if (m_disc > 0) m_disc--;
               else if (m_pend.size() > 0) begin
                  m_rpc.push_back(m_pend.pop_front());
                  m_rinst.push_back(rdata);
               end
            end
            if (e_req && gnt) begin
               m_pend.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst_n     = 1'b1;
      stall     = '0;
      jump_flag = 1'b0;
      jump_addr = '0;
      gnt       = 1'b0;
      rvalid    = 1'b0;
      rdata     = '0;
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_reset("por");
      @(posedge clk);
      #1;
      step();
      step();
      rst_n = 1'b1;

      // zero-wait free run
      repeat (12) step();

      // hold IF/ID for 5 cycles, then other stall bits only
      stall = 6'b000010;
      repeat (5) step();
      stall = 6'b111101;
      repeat (6) step();
      stall = '0;

      // grant wait states
      gnt_pct = 0;
      repeat (3) step();
      gnt_pct = 100;
      repeat (4) step();

      // redirect with two responses in flight
      rv_pct = 0;
      repeat (3) step();
      rv_pct    = 100;
      jump_flag = 1'b1;
      jump_addr = 32'h0000_2002;
      step();
      jump_flag = 1'b0;
      repeat (6) step();

      // redirect on an rvalid, second redirect the next cycle
      rv_pct = 0;
      repeat (2) step();
      rv_pct    = 100;
      jump_flag = 1'b1;
      jump_addr = 32'h0000_3000;
      step();
      jump_addr = 32'h0000_4004;
      step();
      jump_flag = 1'b0;
      repeat (6) step();

      // PC wraps past the top of the address space
      jump_flag = 1'b1;
      jump_addr = 32'hFFFF_FFF9;
      step();
      jump_flag = 1'b0;
      repeat (6) step();

      // reset in the middle of a burst
      #2 rst_n = 1'b0;
      #1 check_reset("mid");
      model_reset();
      step();
      step();
      rst_n = 1'b1;
      repeat (6) step();

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) begin
            gnt_pct = $urandom_range(100, 40);
            rv_pct  = $urandom_range(100, 30);
         end
         stall     = 6'($urandom);
         stall[1]  = ($urandom_range(99) < 30);
         jump_flag = ($urandom_range(99) < 5);
         jump_addr = $urandom;
         step();
      end
      jump_flag = 1'b0;
      stall     = '0;
      gnt_pct   = 100;
      rv_pct    = 100;
      repeat (8) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
